banner_sprite_engine: RTL
=========================

Name: banner_sprite_engine

Overview:
- Parametrised, pipelined full-screen message banner renderer (WIN / LOSE / READY / PAUSED) for the VGA pixel path.
- Holds NUM_MSGS monochrome bitmaps in a registered ROM and maps DrawX/DrawY onto a scaled, positioned bitmap.
- Animates a top-down row reveal followed by optional blinking, paced by frame_clk.
- Its pixel_on output feeds the color mapper, which gives the banner priority over maze, dots and sprites.

Parameters:
BMP_W, 64, bitmap width in pixels (bits per ROM word)
BMP_H, 32, bitmap rows per message
NUM_MSGS, 4, number of stored messages
SCALE_LOG2, 1, on-screen magnification is 2^SCALE_LOG2 in both axes
POS_X, 256, screen X of the banner's left edge
POS_Y, 208, screen Y of the banner's top edge
REVEAL_STEP, 2, rows uncovered per frame tick during reveal
BLINK_FRAMES, 30, frame ticks per blink half-period; 0 disables blinking

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  asynchronous, active-high reset
frame_clk  in  1  VGA vertical sync, asynchronous to Clk; its rising edge marks a frame
show  in  1  level request to display a banner
msg_sel  in  $clog2(NUM_MSGS)  message index, sampled only when leaving IDLE
DrawX  in  10  current pixel X
DrawY  in  10  current pixel Y
pixel_on  out  1  banner pixel lit; valid 2 Clk cycles after DrawX/DrawY
active  out  1  FSM is in REVEAL or SHOW
reveal_done  out  1  FSM is in SHOW

Behaviour:
- Reset (async, active-high): every output is 0; FSM goes to IDLE; rows_shown, blink_cnt, blink_phase, msg_q and all pipeline registers are 0.
- Frame tick: frame_clk passes through a 2-flop synchroniser, then a rising-edge detector. frame_tick is a one-Clk pulse per VSYNC rising edge.
- FSM: IDLE, REVEAL, SHOW.
  - IDLE with show=1: latch msg_sel into msg_q, set rows_shown=0, go to REVEAL next cycle.
  - REVEAL, on frame_tick: rows_shown = min(rows_shown+REVEAL_STEP, BMP_H). When the saturated result equals BMP_H, go to SHOW in the same update. Clear blink_cnt and blink_phase.
  - SHOW, on frame_tick with BLINK_FRAMES>0: blink_cnt++. When blink_cnt reaches BLINK_FRAMES-1, clear it and toggle blink_phase.
  - show=0 in any state: IDLE next cycle; rows_shown, blink_cnt and blink_phase cleared. This takes priority over a simultaneous frame_tick.
- msg_sel changes while active are ignored. A new message requires show to go low for at least one cycle.
- msg_sel >= NUM_MSGS is clamped to NUM_MSGS-1 at latch time.
- Pixel pipeline (runs every cycle, independent of the FSM):
  - Stage 1 (registered):
    - rel_x = {1'b0,DrawX} - POS_X and rel_y = {1'b0,DrawY} - POS_Y, both 11-bit two's complement.
    - inside = rel_x >= 0 && rel_x < BMP_W<<SCALE_LOG2 && rel_y >= 0 && rel_y < BMP_H<<SCALE_LOG2.
    - col = rel_x >> SCALE_LOG2; row = rel_y >> SCALE_LOG2.
    - ROM address = msg_q*BMP_H + row (0 when !inside).
  - Stage 2 (registered): the ROM word arrives from the synchronous ROM read.
    - pixel_on = inside_d & word[BMP_W-1-col_d] & (row_d < rows_shown) & active & ~blink_phase.
    - The gating terms use FSM values current at the stage-2 clock edge.
- Latency: DrawX/DrawY to pixel_on is exactly 2 cycles. Throughput is 1 pixel per cycle.
- Boundaries:
  - DrawX < POS_X (negative rel_x) gives pixel_on=0.
  - Right/bottom edges are exclusive: DrawX = POS_X + (BMP_W<<SCALE_LOG2) gives 0.
  - The final REVEAL step saturates at BMP_H and never exceeds it.
  - Reset mid-reveal blanks output immediately (async clear of the stage-2 register).
- ROM contents: message 0 = WIN, 1 = LOSE, 2 = READY, 3 = PAUSED. Bit BMP_W-1 is the leftmost column.
  - Message 0 row 5 = 64'h0000_00F8_0000_0000 (columns 24-28 lit).
  - Message 0 rows 0-4 = 0.

Decomposition:
- Package banner_pkg holds:
  - the msg_e enum (MSG_WIN, MSG_LOSE, MSG_READY, MSG_PAUSED);
  - the banner_state_e enum (IDLE, REVEAL, SHOW);
  - default geometry constants.
- One sub-module, banner_rom: synchronous read, parametrised on BMP_W, BMP_H and NUM_MSGS, holding the message bitmaps. Its output register is pipeline stage 2's data source.

Test Plan:
- Reset asserted mid-REVEAL with rows_shown=10 -> pixel_on, active and reveal_done are 0 immediately; FSM in IDLE; after release with show=0, outputs stay 0.
- show=1, msg_sel=0, then 3 frame ticks -> rows_shown=6, active=1, reveal_done=0; DrawX=304, DrawY=218 gives pixel_on=1 two cycles later; a lit pixel on row 6 gives 0.
- Continue to 16 frame ticks total -> reveal_done=1 on the 16th tick; a 17th tick leaves rows_shown=32.
- In SHOW, scan DrawY=218 with DrawX=302/304/312/314 -> pixel_on = 0/1/1/0 two cycles later; DrawX=255 and DrawX=384 give 0.
- In SHOW, 30 frame ticks -> blink_phase=1 and pixel_on=0 everywhere; 30 more ticks -> visible again; with BLINK_FRAMES=0 the image never blanks.
- show=1 with msg_sel=1, change msg_sel to 2 while active -> message 1 keeps rendering; drop show for 1 cycle then raise it -> REVEAL restarts with message 2 and rows_shown=0; show drop coincident with frame_tick -> IDLE.

Source files
------------

// File: rtl/banner_pkg.sv
// banner_pkg
// Shared types and default geometry for the banner renderer.
//   msg_e          : index of each stored message bitmap
//   banner_state_e : reveal/blink controller states
//   DEF_*          : default parameter values used by banner_sprite_engine
//                    and banner_rom
package banner_pkg;

  typedef enum logic [1:0] {
    MSG_WIN    = 2'd0,
    MSG_LOSE   = 2'd1,
    MSG_READY  = 2'd2,
    MSG_PAUSED = 2'd3
  } msg_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REVEAL = 2'd1,
    SHOW   = 2'd2
  } banner_state_e;

  localparam int DEF_BMP_W        = 64;
  localparam int DEF_BMP_H        = 32;
  localparam int DEF_NUM_MSGS     = 4;
  localparam int DEF_SCALE_LOG2   = 1;
  localparam int DEF_POS_X        = 256;
  localparam int DEF_POS_Y        = 208;
  localparam int DEF_REVEAL_STEP  = 2;
  localparam int DEF_BLINK_FRAMES = 30;

endpackage

// File: rtl/banner_rom.sv
// banner_rom
// Synchronous-read bitmap ROM holding NUM_MSGS messages of BMP_H rows each.
// Bit BMP_W-1 of a word is the leftmost on-screen column.
// Ports:
//   Clk, Reset : clock, async active-high reset (clears the read register)
//   rd_addr    : msg*BMP_H + row
//   rd_data    : registered bitmap row, one cycle after rd_addr
module banner_rom import banner_pkg::*; #(
  parameter int BMP_W    = DEF_BMP_W,
  parameter int BMP_H    = DEF_BMP_H,
  parameter int NUM_MSGS = DEF_NUM_MSGS,
  parameter int ADDR_W   = $clog2(NUM_MSGS * BMP_H)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [BMP_W-1:0]  rd_data
);

  // Artwork is drawn in a 64-column canvas: a 5-wide bar over the centre
  // of WIN on row 5, then the word in a 5x5 font with each font row doubled
  // (rows 6..15). Each letter sits in one byte, left-aligned, so the words
  // read directly in hex.
  function automatic logic [63:0] glyph_row(input int msg, input int row);
    logic [63:0] g;
    int f;
    g = '0;
    f = (row - 6) / 2;
    if (msg == int'(MSG_WIN) && row == 5) begin
      g = 64'h0000_00F8_0000_0000;
    end else if (row >= 6 && row <= 15) begin
      case (msg)
        int'(MSG_WIN): begin
          case (f)
            0:       g = 64'h0000_8870_8800_0000;
            1:       g = 64'h0000_8820_C800_0000;
            2:       g = 64'h0000_A820_A800_0000;
            3:       g = 64'h0000_A820_9800_0000;
            default: g = 64'h0000_5070_8800_0000;
          endcase
        end
        int'(MSG_LOSE): begin
          case (f)
            0:       g = 64'h0000_8070_78F8_0000;
            1:       g = 64'h0000_8088_8080_0000;
            2:       g = 64'h0000_8088_70F0_0000;
            3:       g = 64'h0000_8088_0880_0000;
            default: g = 64'h0000_F870_F0F8_0000;
          endcase
        end
        int'(MSG_READY): begin
          case (f)
            0:       g = 64'h00F0_F870_F088_0000;
            1:       g = 64'h0088_8088_8850_0000;
            2:       g = 64'h00F0_F0F8_8820_0000;
            3:       g = 64'h00A0_8088_8820_0000;
            default: g = 64'h0090_F888_F020_0000;
          endcase
        end
        int'(MSG_PAUSED): begin
          case (f)
            0:       g = 64'h00F0_7088_78F8_F000;
            1:       g = 64'h0088_8888_8080_8800;
            2:       g = 64'h00F0_F888_70F0_8800;
            3:       g = 64'h0080_8888_0880_8800;
            default: g = 64'h0080_8870_F0F8_F000;
          endcase
        end
        default: g = '0;
      endcase
    end
    return g;
  endfunction

  // Left-align the 64-column artwork into a BMP_W-wide word so narrower or
  // wider bitmaps still show the art from the left edge.
  function automatic logic [BMP_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [BMP_W-1:0] w;
    logic [63:0] g;
    w = '0;
    g = glyph_row(int'(a) / BMP_H, int'(a) % BMP_H);
    for (int i = 0; i < BMP_W; i++) begin
      if (i < 64) w[BMP_W-1-i] = g[63-i];
    end
    return w;
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) rd_data <= '0;
    else       rd_data <= rom_word(rd_addr);
  end

endmodule

// File: rtl/banner_sprite_engine.sv
// banner_sprite_engine
// Full-screen message banner: maps DrawX/DrawY onto a scaled, positioned
// bitmap, reveals it top-down one frame at a time, then optionally blinks.
// Ports:
//   Clk, Reset   : system clock, async active-high reset
//   frame_clk    : VSYNC, asynchronous to Clk; rising edge = new frame
//   show         : level request to display a banner
//   msg_sel      : message index, sampled when leaving IDLE
//   DrawX, DrawY : current pixel coordinate
//   pixel_on     : banner pixel lit, 2 Clk cycles after DrawX/DrawY
//   active       : controller in REVEAL or SHOW
//   reveal_done  : controller in SHOW
module banner_sprite_engine import banner_pkg::*; #(
  parameter int BMP_W        = DEF_BMP_W,
  parameter int BMP_H        = DEF_BMP_H,
  parameter int NUM_MSGS     = DEF_NUM_MSGS,
  parameter int SCALE_LOG2   = DEF_SCALE_LOG2,
  parameter int POS_X        = DEF_POS_X,
  parameter int POS_Y        = DEF_POS_Y,
  parameter int REVEAL_STEP  = DEF_REVEAL_STEP,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
  parameter int MSG_W        = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_clk,
  input  logic             show,
  input  logic [MSG_W-1:0] msg_sel,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  output logic             pixel_on,
  output logic             active,
  output logic             reveal_done
);

  localparam int ADDR_W = $clog2(NUM_MSGS * BMP_H);
  localparam int COL_W  = $clog2(BMP_W);
  localparam int ROW_W  = $clog2(BMP_H);
  localparam int RS_W   = $clog2(BMP_H + 1);
  localparam int BC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [10:0]      X_ORG    = 11'(POS_X);
  localparam logic [10:0]      Y_ORG    = 11'(POS_Y);
  localparam logic [10:0]      X_SPAN   = 11'(BMP_W << SCALE_LOG2);
  localparam logic [10:0]      Y_SPAN   = 11'(BMP_H << SCALE_LOG2);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(BMP_W - 1);

  logic frame_meta, frame_sync, frame_prev, frame_tick;

  banner_state_e    state;
  logic [RS_W-1:0]  rows_shown, rows_next;
  logic [BC_W-1:0]  blink_cnt;
  logic             blink_phase;
  logic [MSG_W-1:0] msg_q, msg_clamped;

  logic [10:0]       rel_x, rel_y;
  logic              in_box;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] rom_addr;
  logic [BMP_W-1:0]  rom_data;
  logic              inside_d;
  logic [COL_W-1:0]  col_d;
  logic [ROW_W-1:0]  row_d;

  // VSYNC crosses into Clk through two flops; the third flop only provides
  // the previous value for edge detection.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_meta <= 1'b0;
      frame_sync <= 1'b0;
      frame_prev <= 1'b0;
    end else begin
      frame_meta <= frame_clk;
      frame_sync <= frame_meta;
      frame_prev <= frame_sync;
    end
  end

  assign frame_tick = frame_sync & ~frame_prev;

  // The last reveal step is clipped to BMP_H so a step that does not divide
  // the height still lands exactly on the bottom row.
  always_comb begin
    if (int'(rows_shown) + REVEAL_STEP >= BMP_H) rows_next = RS_W'(BMP_H);
    else                                         rows_next = rows_shown + RS_W'(REVEAL_STEP);
    if (int'(msg_sel) >= NUM_MSGS) msg_clamped = MSG_W'(NUM_MSGS - 1);
    else                           msg_clamped = msg_sel;
  end

  // Dropping show wins over everything, including a frame tick in the same
  // cycle, so a new message always restarts from a blank banner.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      rows_shown  <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      msg_q       <= '0;
    end else if (!show) begin
      state       <= IDLE;
      rows_shown  <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          msg_q       <= msg_clamped;
          rows_shown  <= '0;
          blink_cnt   <= '0;
          blink_phase <= 1'b0;
          state       <= REVEAL;
        end
        REVEAL: begin
          blink_cnt   <= '0;
          blink_phase <= 1'b0;
          if (frame_tick) begin
            rows_shown <= rows_next;
            if (int'(rows_next) == BMP_H) state <= SHOW;
          end
        end
        SHOW: begin
          if (frame_tick && BLINK_FRAMES > 0) begin
            if (int'(blink_cnt) == BLINK_FRAMES - 1) begin
              blink_cnt   <= '0;
              blink_phase <= ~blink_phase;
            end else begin
              blink_cnt <= blink_cnt + BC_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign active      = (state == REVEAL) || (state == SHOW);
  assign reveal_done = (state == SHOW);

  // Stage 1 address generation. A set sign bit means the pixel lies left of
  // or above the banner; the ROM register itself is the stage-1 data latch.
  always_comb begin
    rel_x    = {1'b0, DrawX} - X_ORG;
    rel_y    = {1'b0, DrawY} - Y_ORG;
    in_box   = ~rel_x[10] && (rel_x < X_SPAN) && ~rel_y[10] && (rel_y < Y_SPAN);
    col      = COL_W'(rel_x >> SCALE_LOG2);
    row      = ROW_W'(rel_y >> SCALE_LOG2);
    rom_addr = in_box ? ADDR_W'(int'(msg_q) * BMP_H + int'(row)) : '0;
  end

  banner_rom #(
    .BMP_W    (BMP_W),
    .BMP_H    (BMP_H),
    .NUM_MSGS (NUM_MSGS),
    .ADDR_W   (ADDR_W)
  ) u_rom (
    .Clk     (Clk),
    .Reset   (Reset),
    .rd_addr (rom_addr),
    .rd_data (rom_data)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      inside_d <= 1'b0;
      col_d    <= '0;
      row_d    <= '0;
    end else begin
      inside_d <= in_box;
      col_d    <= col;
      row_d    <= row;
    end
  end

  // Stage 2 gates the fetched bit with the controller state as it stands at
  // this edge, so reveal/blink changes take effect on the next output pixel.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pixel_on <= 1'b0;
    end else begin
      pixel_on <= inside_d & rom_data[LAST_COL - col_d] &
                  (RS_W'(row_d) < rows_shown) & active & ~blink_phase;
    end
  end

endmodule
